hazard_scoreboard: RTL

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

---
 rtl/hazard_scoreboard_pkg.sv | 50 +++++
 rtl/hazard_scoreboard_instr_decode.sv | 55 +++++
 rtl/hazard_scoreboard.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/hazard_scoreboard_pkg.sv
// Shared definitions for the hazard scoreboard: opcode map, instruction
// field positions, hazard cause codes and the decoded-instruction record.
package hazard_scoreboard_pkg;

    localparam int OPC_W       = 4;
    localparam int REG_FIELD_W = 4;
    localparam int RD_LSB      = 8;
    localparam int RS1_LSB     = 4;
    localparam int RS2_LSB     = 0;

    typedef enum logic [OPC_W-1:0] {
        OP_NOP = 4'd0,
        OP_ADD = 4'd1,
        OP_SUB = 4'd2,
        OP_AND = 4'd3,
        OP_OR  = 4'd4,
        OP_LW  = 4'd8,
        OP_SW  = 4'd9,
        OP_BEQ = 4'd10,
        OP_JMP = 4'd11,
        OP_RET = 4'd12
    } opcode_e;

    typedef enum logic [1:0] {
        CAUSE_NONE  = 2'd0,
        CAUSE_RAW   = 2'd1,
        CAUSE_CTRL  = 2'd2,
        CAUSE_FLUSH = 2'd3
    } cause_e;

    typedef struct packed {
        logic [REG_FIELD_W-1:0] rd;
        logic [REG_FIELD_W-1:0] rs1;
        logic [REG_FIELD_W-1:0] rs2;
        logic [REG_FIELD_W-1:0] base;
        logic                   uses_rs1;
        logic                   uses_rs2;
        logic                   uses_rd_src;
        logic                   uses_base;
        logic                   writes_rd;
        logic                   is_load;
        logic                   is_ctrl;
    } decode_t;

    // Larger of two integers, used for sizing counters at elaboration.
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/hazard_scoreboard_instr_decode.sv
// Purely combinational instruction decoder: extracts register fields and
// classifies which registers the instruction reads and writes.
module instr_decode
    import hazard_scoreboard_pkg::*;
#(
    parameter int IW       = 16,
    parameter int BASE_REG = 14
) (
    input  logic [IW-1:0] instr,
    output decode_t       dec
);

    logic [OPC_W-1:0] opc_s;

    assign opc_s = instr[IW-1 -: OPC_W];

    // Field extraction and per-opcode read/write classification.
    always_comb begin
        dec             = '0;
        dec.rd          = instr[RD_LSB  +: REG_FIELD_W];
        dec.rs1         = instr[RS1_LSB +: REG_FIELD_W];
        dec.rs2         = instr[RS2_LSB +: REG_FIELD_W];
        dec.base        = REG_FIELD_W'(BASE_REG);
        case (opc_s)
            OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                dec.uses_rs1  = 1'b1;
                dec.uses_rs2  = 1'b1;
                dec.writes_rd = 1'b1;
            end
            OP_LW: begin
                // Address comes from the implicit base register.
                dec.uses_base = 1'b1;
                dec.writes_rd = 1'b1;
                dec.is_load   = 1'b1;
            end
            OP_SW: begin
                // rd field carries the data being stored.
                dec.uses_base   = 1'b1;
                dec.uses_rd_src = 1'b1;
            end
            OP_BEQ: begin
                dec.uses_rs1 = 1'b1;
                dec.uses_rs2 = 1'b1;
                dec.is_ctrl  = 1'b1;
            end
            OP_JMP, OP_RET: begin
                dec.is_ctrl = 1'b1;
            end
            default: begin
                dec.writes_rd = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Issue-stage hazard scoreboard: per-register latency down-counters and a
// control-hazard counter gate instruction acceptance, report the stall cause
// and count stalled cycles.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int IW       = 16,
    parameter int NUM_REGS = 16,
    parameter int LAT_ALU  = 2,
    parameter int LAT_LOAD = 3,
    parameter int CTRL_LAT = 3,
    parameter bit FWD_EN   = 1'b0,
    parameter int BASE_REG = 14
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          issue_valid,
    input  logic [IW-1:0] issue_instr,
    output logic          issue_ready,
    input  logic          flush,
    output logic [1:0]    hazard_cause,
    output logic          busy,
    output logic [15:0]   stall_count
);

    localparam int CNT_MAX = max_int(LAT_LOAD, CTRL_LAT);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0]    cnt_q [NUM_REGS];
    logic [CNT_W-1:0]    cnt_d [NUM_REGS];
    logic [CNT_W-1:0]    ctrl_cnt_q;
    logic [CNT_W-1:0]    ctrl_cnt_d;
    logic [15:0]         stall_count_q;
    logic [15:0]         stall_count_d;

    decode_t             dec_s;
    logic [NUM_REGS-1:0] pending_s;
    logic                raw_s;
    logic                ready_s;
    logic                fire_s;
    logic [CNT_W-1:0]    lat_s;
    cause_e              cause_s;

    instr_decode #(
        .IW       (IW),
        .BASE_REG (BASE_REG)
    ) u_decode (
        .instr (issue_instr),
        .dec   (dec_s)
    );

    // A register is a hazard source only when read, non-zero and still pending.
    function automatic logic reg_pending(input logic                   used_f,
                                         input logic [REG_FIELD_W-1:0] idx,
                                         input logic [NUM_REGS-1:0]    pend);
        return used_f && (idx != {REG_FIELD_W{1'b0}}) &&
               (int'(idx) < NUM_REGS) && pend[idx];
    endfunction

    // Pending-write map and RAW detection over every source the instruction reads.
    always_comb begin
        pending_s = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            pending_s[r] = (cnt_q[r] != CNT_ZERO);
        end
        raw_s = reg_pending(dec_s.uses_rs1,    dec_s.rs1,  pending_s) ||
                reg_pending(dec_s.uses_rs2,    dec_s.rs2,  pending_s) ||
                reg_pending(dec_s.uses_rd_src, dec_s.rd,   pending_s) ||
                reg_pending(dec_s.uses_base,   dec_s.base, pending_s);
    end

    // Acceptance and write latency of the presented instruction.
    always_comb begin
        ready_s = rst_n && !flush && (ctrl_cnt_q == CNT_ZERO) && !raw_s;
        fire_s  = issue_valid && ready_s;
        if (FWD_EN) begin
            lat_s = dec_s.is_load ? CNT_ONE : CNT_ZERO;
        end else begin
            lat_s = dec_s.is_load ? CNT_W'(LAT_LOAD) : CNT_W'(LAT_ALU);
        end
    end

    // Next counter values: a new write load wins over the running decrement.
    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            cnt_d[r] = CNT_ZERO;
            if (r == 0) begin
                cnt_d[r] = CNT_ZERO;
            end else if (fire_s && dec_s.writes_rd && (int'(dec_s.rd) == r)) begin
                cnt_d[r] = lat_s;
            end else if (cnt_q[r] != CNT_ZERO) begin
                cnt_d[r] = cnt_q[r] - CNT_ONE;
            end else begin
                cnt_d[r] = CNT_ZERO;
            end
        end

        // Flush redirects the front end, so no control shadow remains.
        ctrl_cnt_d = CNT_ZERO;
        if (flush) begin
            ctrl_cnt_d = CNT_ZERO;
        end else if (fire_s && dec_s.is_ctrl) begin
            ctrl_cnt_d = CNT_W'(CTRL_LAT);
        end else if (ctrl_cnt_q != CNT_ZERO) begin
            ctrl_cnt_d = ctrl_cnt_q - CNT_ONE;
        end else begin
            ctrl_cnt_d = CNT_ZERO;
        end

        stall_count_d = stall_count_q;
        if (issue_valid && !ready_s && (stall_count_q != 16'hFFFF)) begin
            stall_count_d = stall_count_q + 16'd1;
        end else begin
            stall_count_d = stall_count_q;
        end
    end

    // Stall cause with flush over control over RAW priority.
    always_comb begin
        cause_s = CAUSE_NONE;
        if (!rst_n || !issue_valid) begin
            cause_s = CAUSE_NONE;
        end else if (flush) begin
            cause_s = CAUSE_FLUSH;
        end else if (ctrl_cnt_q != CNT_ZERO) begin
            cause_s = CAUSE_CTRL;
        end else if (raw_s) begin
            cause_s = CAUSE_RAW;
        end else begin
            cause_s = CAUSE_NONE;
        end
    end

    // Scoreboard state registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt_q[r] <= CNT_ZERO;
            end
            ctrl_cnt_q    <= CNT_ZERO;
            stall_count_q <= 16'd0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
            ctrl_cnt_q    <= ctrl_cnt_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign issue_ready  = ready_s;
    assign hazard_cause = cause_s;
    assign busy         = rst_n && ((|pending_s) || (ctrl_cnt_q != CNT_ZERO));
    assign stall_count  = stall_count_q;

endmodule
